// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Purpose  : WIDTH-bit arithmetic/logic unit. The result y is purely
//            combinational. The status flags {C, V, Z, N} are captured in a
//            4-bit register on every rising clock edge. This block also serves
//            as the datapath adder of the Fibonacci sequencer (opcode 000).
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports (positional order: clk, s, a, b, f, y, rst)
//   clk  in   1      clock; the flag register loads on the rising edge
//   s    in   3      opcode
//                      000 add   001 sub   010 and   011 or
//                      100 xor   101 not   110 slt   111 pass
//   a    in   WIDTH  operand A (unsigned or two's complement)
//   b    in   WIDTH  operand B
//   f    out  4      registered flags {C, V, Z, N}: f[3]=C ... f[0]=N
//   y    out  WIDTH  combinational result
//   rst  in   1      asynchronous reset, active low; clears f only
// ============================================================================
module alu #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic [2:0]       s,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [3:0]       f,
  output logic [WIDTH-1:0] y,
  input  logic             rst
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOT  = 3'b101;
  localparam logic [2:0] OP_SLT  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  localparam int MSB = WIDTH - 1;

  // Zero-extended add and subtract. The extra top bit is the carry for the
  // add. For the subtract it is set exactly when the difference went
  // negative, i.e. when unsigned a < b, which is the borrow.
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic             slt_bit;

  logic [WIDTH-1:0] y_d;
  logic             carry_d;
  logic             ovf_d;
  logic             zero_d;
  logic             neg_d;
  logic [3:0]       flags_d;
  logic [3:0]       flags_q;

  always_comb begin
    sum_ext  = {1'b0, a} + {1'b0, b};
    diff_ext = {1'b0, a} - {1'b0, b};
    slt_bit  = ($signed(a) < $signed(b));
  end

  // Result selection and the C/V flags. Each operation only sets the
  // carry/overflow of its own kind; logic operations leave C and V at 0.
  always_comb begin
    y_d     = '0;
    carry_d = 1'b0;
    ovf_d   = 1'b0;
    case (s)
      OP_ADD: begin
        y_d     = sum_ext[WIDTH-1:0];
        carry_d = sum_ext[WIDTH];
        // Like-signed operands whose sum flips sign.
        ovf_d   = (a[MSB] == b[MSB]) && (sum_ext[MSB] != a[MSB]);
      end
      OP_SUB: begin
        y_d     = diff_ext[WIDTH-1:0];
        carry_d = diff_ext[WIDTH];
        // Unlike-signed operands whose difference takes the sign of b.
        ovf_d   = (a[MSB] != b[MSB]) && (diff_ext[MSB] != a[MSB]);
      end
      OP_AND:  y_d = a & b;
      OP_OR:   y_d = a | b;
      OP_XOR:  y_d = a ^ b;
      OP_NOT:  y_d = ~a;
      OP_SLT:  y_d = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_PASS: y_d = b;
      default: y_d = '0;
    endcase
  end

  // Z and N are derived from the final result for every opcode.
  always_comb begin
    zero_d  = (y_d == '0);
    neg_d   = y_d[MSB];
    flags_d = {carry_d, ovf_d, zero_d, neg_d};
  end

  // The only state in the block. Reset clears the flags immediately and
  // holds them at zero; the first edge after release loads them normally.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flags_q <= 4'b0000;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign y = y_d;
  assign f = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu
// Purpose  : Self-checking bench for alu. Expected flag values are queued
//            when operands are driven and popped once the clock edge that
//            loads them has passed. y is compared in the same cycle.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu;

  localparam int WIDTH = 6;

  logic             clk;
  logic             rst;
  logic [2:0]       s;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       f;
  logic [WIDTH-1:0] y;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];

  alu #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .s   (s),
    .a   (a),
    .b   (b),
    .f   (f),
    .y   (y),
    .rst (rst)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no summary, expected completion");
    $fatal(1, "timeout");
  end

  // Reference model in plain integer arithmetic.
  function automatic int to_signed(input int v);
    return (v >= 32) ? v - 64 : v;
  endfunction

  function automatic logic [WIDTH-1:0] ref_y(input logic [2:0] op,
                                             input logic [WIDTH-1:0] av,
                                             input logic [WIDTH-1:0] bv);
    int ia;
    int ib;
    int r;
    ia = int'(av);
    ib = int'(bv);
    case (op)
      3'd0: r = (ia + ib) % 64;
      3'd1: r = (ia - ib + 64) % 64;
      3'd2: r = ia & ib;
      3'd3: r = ia | ib;
      3'd4: r = ia ^ ib;
      3'd5: r = 63 - ia;
      3'd6: r = (to_signed(ia) < to_signed(ib)) ? 1 : 0;
      default: r = ib;
    endcase
    return r[WIDTH-1:0];
  endfunction

  function automatic logic [3:0] ref_f(input logic [2:0] op,
                                       input logic [WIDTH-1:0] av,
                                       input logic [WIDTH-1:0] bv);
    int ia;
    int ib;
    int sr;
    logic c;
    logic v;
    logic [WIDTH-1:0] r;
    ia = int'(av);
    ib = int'(bv);
    c  = 1'b0;
    v  = 1'b0;
    if (op == 3'd0) begin
      c  = (ia + ib) > 63;
      sr = to_signed(ia) + to_signed(ib);
      v  = (sr > 31) || (sr < -32);
    end else if (op == 3'd1) begin
      c  = ia < ib;
      sr = to_signed(ia) - to_signed(ib);
      v  = (sr > 31) || (sr < -32);
    end
    r = ref_y(op, av, bv);
    return {c, v, (r == 0), r[WIDTH-1]};
  endfunction

  task automatic drive(input logic [2:0] op, input logic [WIDTH-1:0] av,
                       input logic [WIDTH-1:0] bv, input logic [3:0] ef);
    s = op;
    a = av;
    b = bv;
    exp_q.push_back(ef);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    s = 3'b000;
    a = 6'd63;
    b = 6'd1;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (f !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async: f=%b expected 0000", f);
    end
    tick();
    checks++;
    if (f !== 4'b0000) begin
      errors++;
      $display("FAIL reset_hold: f=%b expected 0000", f);
    end
    checks++;
    if (y !== 6'd0) begin
      errors++;
      $display("FAIL reset_y: y=%0d expected 0", y);
    end
    rst = 1'b1;
  endtask

  task automatic test_add_wrap();
    logic [WIDTH-1:0] av[3];
    logic [WIDTH-1:0] bv[3];
    logic [WIDTH-1:0] ey[3];
    logic [3:0]       ef[3];
    logic [3:0]       got;
    av = '{6'd1,  6'd31, 6'd63};
    bv = '{6'd1,  6'd1,  6'd1};
    ey = '{6'd2,  6'd32, 6'd0};
    ef = '{4'b0000, 4'b0101, 4'b1010};
    for (int i = 0; i < 3; i++) begin
      drive(3'b000, av[i], bv[i], ef[i]);
      #1;
      checks++;
      if (y !== ey[i]) begin
        errors++;
        $display("FAIL add_y[%0d]: y=%0d expected %0d", i, y, ey[i]);
      end
      tick();
      got = exp_q.pop_front();
      checks++;
      if (f !== got) begin
        errors++;
        $display("FAIL add_f[%0d]: f=%b expected %b", i, f, got);
      end
    end
  endtask

  // Runs while f = 1010 from the wrap case, so clearing is observable.
  task automatic test_reset_mid();
    s = 3'b000;
    a = 6'd63;
    b = 6'd2;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (f !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_f: f=%b expected 0000", f);
    end
    checks++;
    if (y !== 6'd1) begin
      errors++;
      $display("FAIL reset_mid_y: y=%0d expected 1", y);
    end
    tick();
    checks++;
    if (f !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_hold: f=%b expected 0000", f);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (f !== 4'b1000) begin
      errors++;
      $display("FAIL reset_release: f=%b expected 1000", f);
    end
  endtask

  task automatic test_sub();
    logic [WIDTH-1:0] av[2];
    logic [WIDTH-1:0] bv[2];
    logic [WIDTH-1:0] ey[2];
    logic [3:0]       ef[2];
    logic [3:0]       got;
    av = '{6'd5, 6'd7};
    bv = '{6'd7, 6'd7};
    ey = '{6'd62, 6'd0};
    ef = '{4'b1001, 4'b0010};
    for (int i = 0; i < 2; i++) begin
      drive(3'b001, av[i], bv[i], ef[i]);
      #1;
      checks++;
      if (y !== ey[i]) begin
        errors++;
        $display("FAIL sub_y[%0d]: y=%0d expected %0d", i, y, ey[i]);
      end
      tick();
      got = exp_q.pop_front();
      checks++;
      if (f !== got) begin
        errors++;
        $display("FAIL sub_f[%0d]: f=%b expected %b", i, f, got);
      end
    end
  endtask

  task automatic test_logic();
    logic [2:0]       op[7];
    logic [WIDTH-1:0] av[7];
    logic [WIDTH-1:0] bv[7];
    logic [WIDTH-1:0] ey[7];
    logic [3:0]       ef[7];
    logic [3:0]       got;
    op = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b111, 3'b110, 3'b110};
    av = '{6'h2A, 6'h2A, 6'h2A, 6'h2A, 6'h2A, 6'h3F, 6'h01};
    bv = '{6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h01, 6'h3F};
    ey = '{6'h0A, 6'h2F, 6'h25, 6'h15, 6'h0F, 6'h01, 6'h00};
    ef = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
    for (int i = 0; i < 7; i++) begin
      drive(op[i], av[i], bv[i], ef[i]);
      #1;
      checks++;
      if (y !== ey[i]) begin
        errors++;
        $display("FAIL logic_y[op=%b]: y=%h expected %h", op[i], y, ey[i]);
      end
      tick();
      got = exp_q.pop_front();
      checks++;
      if (f !== got) begin
        errors++;
        $display("FAIL logic_f[op=%b]: f=%b expected %b", op[i], f, got);
      end
    end
  endtask

  // Back-to-back random operations against the integer model.
  task automatic test_back_to_back();
    logic [2:0]       op;
    logic [WIDTH-1:0] av;
    logic [WIDTH-1:0] bv;
    logic [WIDTH-1:0] ey;
    logic [3:0]       got;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      av = 6'($urandom_range(0, 63));
      bv = 6'($urandom_range(0, 63));
      ey = ref_y(op, av, bv);
      drive(op, av, bv, ref_f(op, av, bv));
      #1;
      checks++;
      if (y !== ey) begin
        errors++;
        $display("FAIL rand_y[%0d] op=%b a=%0d b=%0d: y=%0d expected %0d",
                 i, op, av, bv, y, ey);
      end
      tick();
      got = exp_q.pop_front();
      checks++;
      if (f !== got) begin
        errors++;
        $display("FAIL rand_f[%0d] op=%b a=%0d b=%0d: f=%b expected %b",
                 i, op, av, bv, f, got);
      end
    end
  endtask

  task automatic test_fibonacci();
    logic [WIDTH-1:0] r0;
    logic [WIDTH-1:0] r1;
    logic [WIDTH-1:0] seq[9];
    logic [3:0]       got;
    seq = '{6'd2, 6'd3, 6'd5, 6'd8, 6'd13, 6'd21, 6'd34, 6'd55, 6'd25};
    r0 = 6'd1;
    r1 = 6'd1;
    for (int i = 0; i < 9; i++) begin
      drive(3'b000, r0, r1, ref_f(3'b000, r0, r1));
      #1;
      checks++;
      if (y !== seq[i]) begin
        errors++;
        $display("FAIL fib_y[%0d]: y=%0d expected %0d", i, y, seq[i]);
      end
      tick();
      got = exp_q.pop_front();
      checks++;
      if (f !== got) begin
        errors++;
        $display("FAIL fib_f[%0d]: f=%b expected %b", i, f, got);
      end
      r0 = r1;
      r1 = seq[i];
    end
    checks++;
    if (f[3] !== 1'b1) begin
      errors++;
      $display("FAIL fib_carry: C=%b expected 1", f[3]);
    end
  endtask

  initial begin
    rst = 1'b1;
    s   = 3'b000;
    a   = '0;
    b   = '0;
    test_reset();
    test_add_wrap();
    test_reset_mid();
    test_sub();
    test_logic();
    test_back_to_back();
    test_fibonacci();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu.md
# alu

Combinational WIDTH-bit arithmetic/logic unit with a registered status-flag output. It is the datapath adder of the Fibonacci sequencer, which uses opcode 000 to form r0 + r1. The result is also usable as a general-purpose ALU elsewhere in the lab datapaths. Result is combinational; flags are captured on the clock edge.

## Interface
- WIDTH, 6, operand/result width in bits (minimum 2)
- clk  input  1  clock; flag register updates on rising edge
- rst  input  1  reset, asynchronous, active-low (0 = reset)
- s  input  3  opcode
- a  input  WIDTH  operand A (unsigned or two's complement)
- b  input  WIDTH  operand B
- f  output  4  registered flags {C, V, Z, N}, f[3]=C … f[0]=N
- y  output  WIDTH  combinational result
- Positional port order is clk, s, a, b, f, y, rst. Existing positional instances (clk, s, a, b, unconnected, y) stay valid for y.

## Operation
- Opcodes for y:
  - 000 add: y = a + b mod 2^WIDTH
  - 001 sub: y = a − b mod 2^WIDTH
  - 010 and: y = a & b
  - 011 or: y = a | b
  - 100 xor: y = a ^ b
  - 101 not: y = ~a (b ignored)
  - 110 slt: y = 1 if signed(a) < signed(b), else 0, zero-extended
  - 111 pass: y = b
- Next-flag values, computed combinationally from the current s/a/b/y:
  - C, add: carry out of bit WIDTH−1.
  - C, sub: borrow, 1 when unsigned a < b.
  - C, all other ops: 0.
  - V, add: 1 when a and b have the same sign and y's sign differs.
  - V, sub: 1 when a and b have different signs and y's sign differs from a.
  - V, all other ops: 0.
  - Z = (y == 0) for every op.
  - N = y[WIDTH−1] for every op.
- No internal state other than the 4-bit flag register. y never depends on f.

## Timing
- y is purely combinational: zero-cycle latency and valid in the same cycle as a/b/s. Downstream registers may sample y on the same edge.
- f is loaded with the next-flag values on every rising clk edge while rst=1. It reflects the operation present just before that edge, so f has 1 cycle of latency relative to y.
- rst=0 forces f=4'b0000 immediately (asynchronous), independent of clk.
- While rst=0, f holds 0 across clock edges.
- y is unaffected by rst and keeps following the inputs during reset.
- Reset deassertion (rst 0→1) takes effect at the next rising edge, which loads flags normally.
- X/Z on s must not be produced by a correct bench. For any opcode not decoded, the default branch is y = 0, with flags as defined for "other ops".

## Test plan
- Reset: assert rst=0 mid-run while f≠0 -> f=0000 without a clock edge; y still equals a+b for s=000.
- Add and wrap: s=000, a=1, b=1 -> y=2 immediately; after edge f=0000. Then a=63, b=1 -> y=0; after edge C=1, Z=1, V=0, N=0.
- Signed overflow: s=000, a=31, b=1 -> y=32; after edge V=1, N=1, C=0, Z=0.
- Subtract: s=001, a=5, b=7 -> y=62; after edge C=1, N=1, V=0, Z=0. Then a=7, b=7 -> y=0 and Z=1 after the edge.
- Logic and misc ops: a=0x2A, b=0x0F:
  - and -> 0x0A
  - or -> 0x2F
  - xor -> 0x25
  - not -> 0x15
  - pass -> 0x0F
  - slt with a=0x3F (−1), b=1 -> y=1
- Fibonacci integration: feed r0=1, r1=1 into s=000 with registers updated from y each cycle -> sequence 2, 3, 5, 8, 13, 21, 34, 55, then 89 mod 64 = 25 with C=1 on that cycle's flags.
